// File: rtl/iic_dac_master.sv
// I2C master for MCP4725-class 12-bit DACs: fast, DAC-register, DAC+EEPROM writes and 3-byte readback.
// Bus timing comes from CLK_DIV; a NACK re-runs the whole transaction up to RETRY_MAX times.
module iic_dac_master #(
  parameter int         CLK_DIV   = 125,
  parameter logic [6:0] DEV_ADDR  = 7'h60,
  parameter int         RETRY_MAX = 3
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic        SCL,
  inout  wire         SDA,
  input  logic        iStart,
  input  logic [1:0]  iMode,
  input  logic [11:0] iCode,
  input  logic [1:0]  iPd,
  output logic        oBusy,
  output logic        oDone,
  output logic        oNack,
  output logic [23:0] oRdData
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [PW-1:0] PH_ZERO = PW'(0);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [PW-1:0] PH_Q    = PW'(CLK_DIV / 4);
  localparam logic [PW-1:0] PH_2Q   = PW'(2 * (CLK_DIV / 4));
  localparam logic [PW-1:0] PH_3Q   = PW'(3 * (CLK_DIV / 4));
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  localparam logic [RW-1:0] RETRY_ZERO = RW'(0);
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_TX    = 4'd2,
    ST_ACK   = 4'd3,
    ST_RX    = 4'd4,
    ST_MACK  = 4'd5,
    ST_STOP  = 4'd6,
    ST_FREE  = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_phase;
  logic [2:0]    r_bit;
  logic [1:0]    r_byte;
  logic [7:0]    r_shift;
  logic [23:0]   r_rx;
  logic [1:0]    r_mode;
  logic [11:0]   r_code;
  logic [1:0]    r_pd;
  logic [RW-1:0] r_retry;
  logic          r_pend;
  logic          r_sample;
  logic          r_busy;
  logic          r_done;
  logic          r_nack;
  logic [23:0]   r_rd;
  logic          r_scl;
  logic          r_sda_low;

  logic          w_last;
  logic          w_sda_in;
  logic [1:0]    w_last_tx;

  // Byte k of the outgoing frame sequence for the given mode (k = 0 is the address byte).
  function automatic logic [7:0] f_tx_byte(input logic [1:0]  idx,
                                           input logic [1:0]  mode,
                                           input logic [11:0] code,
                                           input logic [1:0]  pd);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      2'd0: b = {DEV_ADDR, (mode == 2'b11)};
      2'd1: begin
        if (mode == 2'b00)      b = {2'b00, pd, code[11:8]};
        else if (mode == 2'b10) b = {3'b011, 2'b00, pd, 1'b0};
        else                    b = {3'b010, 2'b00, pd, 1'b0};
      end
      2'd2: begin
        if (mode == 2'b00) b = code[7:0];
        else               b = code[11:4];
      end
      2'd3:    b = {code[3:0], 4'h0};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign w_last   = (r_phase == PH_LAST);
  assign w_sda_in = SDA;

  // Index of the final transmitted byte; readback only sends the address.
  always_comb begin
    w_last_tx = 2'd3;
    case (r_mode)
      2'b00:   w_last_tx = 2'd2;
      2'b11:   w_last_tx = 2'd0;
      default: w_last_tx = 2'd3;
    endcase
  end

  // Transaction sequencer: phase timing, byte framing, retry and request handshake.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state  <= ST_IDLE;
      r_phase  <= PH_ZERO;
      r_bit    <= 3'd0;
      r_byte   <= 2'd0;
      r_shift  <= 8'h00;
      r_rx     <= 24'h000000;
      r_mode   <= 2'b00;
      r_code   <= 12'h000;
      r_pd     <= 2'b00;
      r_retry  <= RETRY_ZERO;
      r_pend   <= 1'b0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_nack   <= 1'b0;
      r_rd     <= 24'h000000;
    end else begin
      r_done  <= 1'b0;
      r_phase <= w_last ? PH_ZERO : (r_phase + PH_ONE);
      case (r_state)
        ST_IDLE: begin
          r_phase <= PH_ZERO;
          // r_busy is still high for the one cycle after oDone, which blocks acceptance there.
          if (iStart && !r_busy) begin
            r_mode  <= iMode;
            r_code  <= iCode;
            r_pd    <= iPd;
            r_busy  <= 1'b1;
            r_nack  <= 1'b0;
            r_state <= ST_START;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_START: begin
          if (w_last) begin
            r_byte  <= 2'd0;
            r_bit   <= 3'd0;
            r_shift <= f_tx_byte(2'd0, r_mode, r_code, r_pd);
            r_state <= ST_TX;
          end
        end
        ST_TX: begin
          if (w_last) begin
            if (r_bit == 3'd7) begin
              r_state <= ST_ACK;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {r_shift[6:0], 1'b0};
            end
          end
        end
        ST_ACK: begin
          if (r_phase == PH_3Q) r_sample <= w_sda_in;
          if (w_last) begin
            if (r_sample) begin
              r_pend  <= 1'b1;
              r_state <= ST_STOP;
            end else if (r_byte == w_last_tx) begin
              r_bit   <= 3'd0;
              r_byte  <= 2'd0;
              r_state <= (r_mode == 2'b11) ? ST_RX : ST_STOP;
            end else begin
              r_byte  <= r_byte + 2'd1;
              r_bit   <= 3'd0;
              r_shift <= f_tx_byte(r_byte + 2'd1, r_mode, r_code, r_pd);
              r_state <= ST_TX;
            end
          end
        end
        ST_RX: begin
          if (r_phase == PH_3Q) r_rx <= {r_rx[22:0], w_sda_in};
          if (w_last) begin
            if (r_bit == 3'd7) r_state <= ST_MACK;
            else               r_bit   <= r_bit + 3'd1;
          end
        end
        ST_MACK: begin
          if (w_last) begin
            if (r_byte == 2'd2) begin
              r_state <= ST_STOP;
            end else begin
              r_byte  <= r_byte + 2'd1;
              r_bit   <= 3'd0;
              r_state <= ST_RX;
            end
          end
        end
        ST_STOP: begin
          if (w_last) r_state <= ST_FREE;
        end
        ST_FREE: begin
          if (w_last) begin
            if (r_pend) begin
              r_pend <= 1'b0;
              if (r_retry < RETRY_LIM) begin
                r_retry <= r_retry + RETRY_ONE;
                r_state <= ST_START;
              end else begin
                r_nack  <= 1'b1;
                r_state <= ST_DONE;
              end
            end else begin
              if (r_mode == 2'b11) r_rd <= r_rx;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_retry <= RETRY_ZERO;
          r_phase <= PH_ZERO;
          r_state <= ST_IDLE;
        end
        default: begin
          r_phase <= PH_ZERO;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered SCL/SDA drivers; they trail the sequencer by one cycle, so SCL and SDA keep their relative timing.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          r_scl     <= 1'b1;
          r_sda_low <= (r_phase >= PH_2Q);
        end
        ST_TX: begin
          r_scl <= (r_phase >= PH_2Q);
          if (r_phase == PH_Q) r_sda_low <= ~r_shift[7];
        end
        ST_ACK, ST_RX: begin
          r_scl <= (r_phase >= PH_2Q);
          if (r_phase == PH_Q) r_sda_low <= 1'b0;
        end
        ST_MACK: begin
          r_scl <= (r_phase >= PH_2Q);
          if (r_phase == PH_Q) r_sda_low <= (r_byte != 2'd2);
        end
        ST_STOP: begin
          r_scl     <= (r_phase >= PH_Q);
          r_sda_low <= (r_phase < PH_2Q);
        end
        default: begin
          r_scl     <= 1'b1;
          r_sda_low <= 1'b0;
        end
      endcase
    end
  end

  assign SCL     = r_scl;
  assign SDA     = r_sda_low ? 1'b0 : 1'bz;
  assign oBusy   = r_busy;
  assign oDone   = r_done;
  assign oNack   = r_nack;
  assign oRdData = r_rd;

endmodule

// File: tb/tb_iic_dac_master.sv
// Directed bench for iic_dac_master: a bit-level I2C slave model decodes the bus and answers with ACK/NACK/data.
`timescale 1ns/1ps
module tb_iic_dac_master;

  localparam int CLK_DIV = 125;

  logic        CLOCK  = 1'b0;
  logic        RESET  = 1'b0;
  logic        iStart = 1'b0;
  logic [1:0]  iMode  = 2'b00;
  logic [11:0] iCode  = 12'h000;
  logic [1:0]  iPd    = 2'b00;
  logic        SCL;
  wire         SDA;
  logic        oBusy, oDone, oNack;
  logic [23:0] oRdData;

  logic        s_low = 1'b0;
  assign SDA = s_low ? 1'b0 : 1'bz;
  pullup (SDA);

  iic_dac_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h60), .RETRY_MAX(3)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .SCL(SCL), .SDA(SDA),
    .iStart(iStart), .iMode(iMode), .iCode(iCode), .iPd(iPd),
    .oBusy(oBusy), .oDone(oDone), .oNack(oNack), .oRdData(oRdData)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave model state
  int          bitn = 0, frame = 0, nb = 0, n_start = 0, n_stop = 0, n_done = 0, nack_left = 0;
  logic        rd = 1'b0;
  logic [7:0]  sh = 8'h00;
  logic [7:0]  bytes_seen [4];
  logic [2:0]  mack = 3'b000;
  logic [23:0] rd_word = 24'h000000;
  logic        scl_p = 1'b1, sda_p = 1'b1;

  always @(negedge CLOCK) begin : slave
    logic scl_n, sda_n;
    scl_n = SCL;
    sda_n = (SDA !== 1'b0);
    if (oDone === 1'b1) n_done++;
    if (scl_p && scl_n && sda_p && !sda_n) begin
      n_start++; bitn = -1; frame = 0; nb = 0; rd = 1'b0; s_low = 1'b0;
    end else if (scl_p && scl_n && !sda_p && sda_n) begin
      n_stop++;
    end else if (!scl_p && scl_n) begin
      if (bitn >= 0 && bitn < 8) sh = {sh[6:0], sda_n};
      else if (bitn == 8 && rd && frame >= 1 && frame <= 3) mack[3-frame] = sda_n;
    end else if (scl_p && !scl_n) begin
      bitn++;
      if (bitn == 8) begin
        if (frame == 0 || !rd) begin
          if (nb < 4) bytes_seen[nb] = sh;
          nb++;
          if (frame == 0) rd = sh[0];
          if (frame == 0 && nack_left > 0) begin
            nack_left--; s_low = 1'b0;
          end else begin
            s_low = 1'b1;
          end
        end else begin
          s_low = 1'b0;
        end
      end else if (bitn == 9) begin
        bitn = 0; frame++;
        s_low = (rd && frame <= 3) ? ~rd_word[8*(3-frame)+7] : 1'b0;
      end else if (rd && frame >= 1 && frame <= 3) begin
        s_low = ~rd_word[8*(3-frame)+7-bitn];
      end
    end
    scl_p = scl_n;
    sda_p = sda_n;
  end

  // lat counts clock edges, the accepting edge being 1, up to the edge that raises oDone.
  task automatic run_txn(input logic [1:0] mode, input logic [11:0] code, input logic [1:0] pd,
                         input bit poke, output int lat);
    n_start = 0; n_stop = 0;
    @(negedge CLOCK);
    iMode = mode; iCode = code; iPd = pd; iStart = 1'b1;
    @(negedge CLOCK);
    iStart = 1'b0;
    lat = 1;
    check("busy_after_accept", 32'(oBusy), 32'd1);
    check("nack_cleared", 32'(oNack), 32'd0);
    while (oDone !== 1'b1 && lat < 20000) begin
      @(negedge CLOCK);
      lat++;
      iStart = (poke && (lat == 200 || lat == 3000)) ? 1'b1 : 1'b0;
    end
    iStart = 1'b0;
    check("done_seen", 32'(oDone), 32'd1);
    check("busy_at_done", 32'(oBusy), 32'd1);
    @(negedge CLOCK);
    check("busy_drop", 32'(oBusy), 32'd0);
    check("done_one_cycle", 32'(oDone), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] code;
    logic [1:0]  pd;
    logic [23:0] slave_rd;
    int          nb_exp;
    logic [31:0] bytes_exp;
    int          lat_exp;
    logic [23:0] rd_exp;
  } vec_t;

  vec_t vecs [4];

  initial begin : main
    int lat;
    vecs[0] = '{2'b00, 12'hABC, 2'b00, 24'h000000, 3, 32'hC00ABC00, 3752, 24'h000000};
    vecs[1] = '{2'b01, 12'h123, 2'b01, 24'h000000, 4, 32'hC0421230, 4877, 24'h000000};
    vecs[2] = '{2'b10, 12'h123, 2'b01, 24'h000000, 4, 32'hC0621230, 4877, 24'h000000};
    vecs[3] = '{2'b11, 12'h000, 2'b00, 24'hC08000, 1, 32'hC1000000, 0,    24'hC08000};

    // Reset state
    repeat (3) @(negedge CLOCK);
    check("rst_scl", 32'(SCL), 32'd1);
    check("rst_sda", 32'(SDA !== 1'b0), 32'd1);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_nack", 32'(oNack), 32'd0);
    check("rst_rd", 32'(oRdData), 32'd0);
    RESET = 1'b1;
    repeat (5) @(negedge CLOCK);

    // Table-driven transactions, slave ACKs everything
    for (int i = 0; i < 4; i++) begin
      rd_word = vecs[i].slave_rd;
      nack_left = 0;
      run_txn(vecs[i].mode, vecs[i].code, vecs[i].pd, 1'b0, lat);
      if (vecs[i].lat_exp != 0) check("latency", 32'(lat), 32'(vecs[i].lat_exp));
      check("starts", 32'(n_start), 32'd1);
      check("stops", 32'(n_stop), 32'd1);
      check("nbytes", 32'(nb), 32'(vecs[i].nb_exp));
      for (int j = 0; j < vecs[i].nb_exp; j++)
        check("byte", 32'(bytes_seen[j]), 32'(vecs[i].bytes_exp[31-8*j -: 8]));
      check("nack", 32'(oNack), 32'd0);
      check("rddata", 32'(oRdData), 32'(vecs[i].rd_exp));
      if (vecs[i].mode == 2'b11) check("master_ack", 32'(mack), 32'd1);
      repeat (10) @(negedge CLOCK);
    end

    // Address NACKed on every attempt: 1 + RETRY_MAX attempts of 12 bit periods each
    nack_left = 100;
    run_txn(2'b00, 12'h555, 2'b00, 1'b0, lat);
    check("exh_latency", 32'(lat), 32'd6002);
    check("exh_starts", 32'(n_start), 32'd4);
    check("exh_stops", 32'(n_stop), 32'd4);
    check("exh_nack", 32'(oNack), 32'd1);
    check("exh_rd_kept", 32'(oRdData), 32'hC08000);
    repeat (10) @(negedge CLOCK);
    check("exh_nack_held", 32'(oNack), 32'd1);
    nack_left = 0;

    // One NACK then success, with iStart pokes while busy
    nack_left = 1;
    n_done = 0;
    run_txn(2'b00, 12'h7F1, 2'b10, 1'b1, lat);
    check("rty_latency", 32'(lat), 32'd5252);
    check("rty_starts", 32'(n_start), 32'd2);
    check("rty_nack", 32'(oNack), 32'd0);
    check("rty_b0", 32'(bytes_seen[0]), 32'hC0);
    check("rty_b1", 32'(bytes_seen[1]), 32'h27);
    check("rty_b2", 32'(bytes_seen[2]), 32'hF1);
    repeat (300) @(negedge CLOCK);
    check("rty_one_done", 32'(n_done), 32'd1);
    check("rty_idle", 32'(oBusy), 32'd0);
    nack_left = 0;

    // Reset in the middle of the address byte
    @(negedge CLOCK);
    iMode = 2'b01; iCode = 12'h456; iPd = 2'b00; iStart = 1'b1;
    @(negedge CLOCK);
    iStart = 1'b0;
    repeat (600) @(negedge CLOCK);
    check("mid_busy", 32'(oBusy), 32'd1);
    RESET = 1'b0;
    @(negedge CLOCK);
    check("mid_rst_scl", 32'(SCL), 32'd1);
    check("mid_rst_sda", 32'(SDA !== 1'b0), 32'd1);
    check("mid_rst_busy", 32'(oBusy), 32'd0);
    check("mid_rst_rd", 32'(oRdData), 32'd0);
    RESET = 1'b1;
    repeat (20) @(negedge CLOCK);
    run_txn(2'b00, 12'h800, 2'b11, 1'b0, lat);
    check("post_latency", 32'(lat), 32'd3752);
    check("post_starts", 32'(n_start), 32'd1);
    check("post_b1", 32'(bytes_seen[1]), 32'h38);
    check("post_b2", 32'(bytes_seen[2]), 32'h00);
    check("post_nack", 32'(oNack), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
